// File: rtl/approx_error_accum.sv
// Streaming error-statistics accumulator for exact/approximate multiplier result pairs.
// Two-stage pipeline: stage 1 forms the per-sample difference, stage 2 folds it into the run statistics.
module approx_error_accum #(
    parameter int W         = 16,
    parameter int CNT_W     = 17,
    parameter int N_SAMPLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [W-1:0]          exact,
    input  logic [W-1:0]          approx,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sample_count,
    output logic [CNT_W-1:0]      err_count,
    output logic [W+CNT_W-1:0]    sum_abs_err,
    output logic signed [W+CNT_W:0] sum_signed_err,
    output logic [W-1:0]          max_abs_err,
    output logic [CNT_W-1:0]      max_at
);

    localparam int ACC_W = W + CNT_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    function automatic logic signed [W:0] diff(input logic [W-1:0] a, input logic [W-1:0] e);
        return $signed({1'b0, a}) - $signed({1'b0, e});
    endfunction

    // Both operands are unsigned W-bit, so the magnitude always fits in W bits.
    function automatic logic [W-1:0] mag(input logic signed [W:0] d);
        return d[W] ? W'(-d) : W'(d);
    endfunction

    function automatic logic signed [ACC_W:0] sext(input logic signed [W:0] d);
        return {{CNT_W{d[W]}}, d};
    endfunction

    logic [1:0]          state;
    logic                start_run;
    logic                accept;
    logic signed [W:0]   diff_p0;

    logic                vld_p1;
    logic signed [W:0]   d_p1;
    logic [W-1:0]        mag_p1;
    logic                ne_p1;
    logic [CNT_W-1:0]    idx_p1;

    assign in_ready  = (state == ACCUM);
    assign busy      = (state == ACCUM) || (state == DRAIN);
    assign done      = (state == DONE);
    assign start_run = start && ((state == IDLE) || (state == DONE));
    assign accept    = in_valid && in_ready;
    assign diff_p0   = diff(approx, exact);

    // Stage 0: control FSM and acceptance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ACCUM;
                        sample_count <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sample_count <= sample_count + CNT_W'(1);
                        if (sample_count == LAST_IDX) state <= DRAIN;
                    end
                end
                DRAIN:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: per-sample difference, magnitude, mismatch flag and index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            d_p1   <= '0;
            mag_p1 <= '0;
            ne_p1  <= 1'b0;
            idx_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                d_p1   <= diff_p0;
                mag_p1 <= mag(diff_p0);
                ne_p1  <= (diff_p0 != '0);
                idx_p1 <= sample_count;
            end
        end
    end

    // Stage 2: run statistics; strict compare keeps the earliest index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            sum_abs_err    <= '0;
            sum_signed_err <= '0;
            max_abs_err    <= '0;
            max_at         <= '0;
        end else if (start_run) begin
            err_count      <= '0;
            sum_abs_err    <= '0;
            sum_signed_err <= '0;
            max_abs_err    <= '0;
            max_at         <= '0;
        end else if (vld_p1) begin
            err_count      <= err_count + CNT_W'(ne_p1);
            sum_abs_err    <= sum_abs_err + {{CNT_W{1'b0}}, mag_p1};
            sum_signed_err <= sum_signed_err + sext(d_p1);
            if (mag_p1 > max_abs_err) begin
                max_abs_err <= mag_p1;
                max_at      <= idx_p1;
            end
        end
    end

endmodule

// File: tb/tb_approx_error_accum.sv
// Directed bench for approx_error_accum: four instances with different run lengths, scoreboard of run results.
module tb_approx_error_accum;

    localparam int W     = 16;
    localparam int CNT_W = 17;
    localparam int ACC_W = W + CNT_W;
    localparam int NU    = 4;

    typedef struct {
        logic signed [63:0] cnt;
        logic signed [63:0] errc;
        logic signed [63:0] sabs;
        logic signed [63:0] ssgn;
        logic signed [63:0] mx;
        logic signed [63:0] mat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                    start          [NU];
    logic                    in_valid       [NU];
    logic [W-1:0]            exact          [NU];
    logic [W-1:0]            approx         [NU];
    logic                    in_ready       [NU];
    logic                    busy           [NU];
    logic                    done           [NU];
    logic [CNT_W-1:0]        sample_count   [NU];
    logic [CNT_W-1:0]        err_count      [NU];
    logic [ACC_W-1:0]        sum_abs_err    [NU];
    logic signed [ACC_W:0]   sum_signed_err [NU];
    logic [W-1:0]            max_abs_err    [NU];
    logic [CNT_W-1:0]        max_at         [NU];

    generate
        for (genvar g = 0; g < NU; g++) begin : g_dut
            approx_error_accum #(
                .W(W),
                .CNT_W(CNT_W),
                .N_SAMPLES(g == 0 ? 4 : g == 1 ? 3 : g == 2 ? 2 : 65536)
            ) dut (
                .clk(clk),
                .rst_n(rst_n),
                .start(start[g]),
                .in_valid(in_valid[g]),
                .exact(exact[g]),
                .approx(approx[g]),
                .in_ready(in_ready[g]),
                .busy(busy[g]),
                .done(done[g]),
                .sample_count(sample_count[g]),
                .err_count(err_count[g]),
                .sum_abs_err(sum_abs_err[g]),
                .sum_signed_err(sum_signed_err[g]),
                .max_abs_err(max_abs_err[g]),
                .max_at(max_at[g])
            );
        end
    endgenerate

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int u, input logic [W-1:0] e, input logic [W-1:0] a);
        in_valid[u] = 1'b1;
        exact[u]    = e;
        approx[u]   = a;
        tick(1);
        in_valid[u] = 1'b0;
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        tick(1);
        start[u] = 1'b0;
    endtask

    task automatic push(input longint cnt, input longint errc, input longint sabs,
                        input longint ssgn, input longint mx, input longint mat);
        exp_t e;
        e.cnt = cnt; e.errc = errc; e.sabs = sabs; e.ssgn = ssgn; e.mx = mx; e.mat = mat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int u, input int limit);
        int n = 0;
        while (done[u] !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk("done_reached", done[u], 1);
    endtask

    task automatic check_result(input int u);
        exp_t e;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sample_count", sample_count[u], e.cnt);
            chk("err_count", err_count[u], e.errc);
            chk("sum_abs_err", sum_abs_err[u], e.sabs);
            chk("sum_signed_err", sum_signed_err[u], e.ssgn);
            chk("max_abs_err", max_abs_err[u], e.mx);
            chk("max_at", max_at[u], e.mat);
        end
    endtask

    task automatic check_zero(input int u);
        chk("rst_sample_count", sample_count[u], 0);
        chk("rst_err_count", err_count[u], 0);
        chk("rst_sum_abs_err", sum_abs_err[u], 0);
        chk("rst_sum_signed_err", sum_signed_err[u], 0);
        chk("rst_max_abs_err", max_abs_err[u], 0);
        chk("rst_max_at", max_at[u], 0);
        chk("rst_in_ready", in_ready[u], 0);
        chk("rst_busy", busy[u], 0);
        chk("rst_done", done[u], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            start[u] = 1'b0; in_valid[u] = 1'b0; exact[u] = '0; approx[u] = '0;
        end
        // Random traffic including start pulses while reset is held
        repeat (4) begin
            for (int u = 0; u < NU; u++) begin
                start[u]    = 1'($urandom_range(0, 1));
                in_valid[u] = 1'($urandom_range(0, 1));
                exact[u]    = 16'($urandom);
                approx[u]   = 16'($urandom);
            end
            tick(1);
        end
        for (int u = 0; u < NU; u++) check_zero(u);
        for (int u = 0; u < NU; u++) begin
            start[u] = 1'b0; in_valid[u] = 1'b0; exact[u] = '0; approx[u] = '0;
        end
        rst_n = 1'b1;
        tick(1);

        pulse_start(0);
        chk("start_in_ready", in_ready[0], 1);
        chk("start_busy", busy[0], 1);
        chk("start_done", done[0], 0);

        // Mixed errors with two idle cycles between samples
        push(4, 3, 10, 0, 5, 1);
        send(0, 10, 12);   tick(2);
        send(0, 50, 45);   tick(2);
        send(0, 7, 7);     tick(2);
        send(0, 1000, 1003);
        wait_done(0, 10);
        check_result(0);

        // Start in DONE clears everything on that edge
        pulse_start(0);
        chk("clr_sample_count", sample_count[0], 0);
        chk("clr_err_count", err_count[0], 0);
        chk("clr_sum_abs_err", sum_abs_err[0], 0);
        chk("clr_max_abs_err", max_abs_err[0], 0);
        chk("clr_max_at", max_at[0], 0);
        chk("clr_in_ready", in_ready[0], 1);
        chk("clr_done", done[0], 0);

        // Exact-match run, back to back, with done timing
        push(4, 0, 0, 0, 0, 0);
        send(0, 100, 100);
        send(0, 200, 200);
        send(0, 300, 300);
        send(0, 400, 400);
        chk("drain_in_ready", in_ready[0], 0);
        chk("drain_busy", busy[0], 1);
        chk("drain_done", done[0], 0);
        tick(1);
        chk("final_done", done[0], 1);
        chk("final_busy", busy[0], 0);
        check_result(0);
        tick(3);
        chk("done_held", done[0], 1);
        chk("count_held", sample_count[0], 4);

        // Protocol edges: start ignored in ACCUM, samples beyond the run ignored
        pulse_start(0);
        push(4, 4, 4, 4, 1, 0);
        send(0, 10, 11);
        send(0, 20, 21);
        pulse_start(0);
        chk("accum_start_count", sample_count[0], 2);
        chk("accum_start_ready", in_ready[0], 1);
        chk("accum_start_busy", busy[0], 1);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exact[0]  = 16'(30 + i);
            approx[0] = 16'(30 + i + (i < 2 ? 1 : 9));
            tick(1);
        end
        in_valid[0] = 1'b0;
        chk("overrun_count", sample_count[0], 4);
        wait_done(0, 10);
        check_result(0);

        // Tie and extremes, N_SAMPLES = 3
        pulse_start(1);
        push(3, 3, 65541, -65535, 65535, 2);
        send(1, 16'd0, 16'd3);
        send(1, 16'd5, 16'd2);
        send(1, 16'hFFFF, 16'd0);
        wait_done(1, 10);
        check_result(1);

        // Tie only, N_SAMPLES = 2: earlier index wins
        pulse_start(2);
        push(2, 2, 6, 0, 3, 0);
        send(2, 16'd0, 16'd3);
        send(2, 16'd5, 16'd2);
        wait_done(2, 10);
        check_result(2);

        // Mid-run asynchronous reset
        pulse_start(0);
        send(0, 1, 5);
        send(0, 2, 9);
        tick(1);
        chk("pre_reset_busy", busy[0], 1);
        chk("pre_reset_abs", sum_abs_err[0], 11);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("post_reset_done", done[0], 0);

        // Full sweep at default run length
        pulse_start(3);
        push(65536, 0, 0, 0, 0, 0);
        in_valid[3] = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            exact[3]  = 16'(i);
            approx[3] = 16'(i);
            tick(1);
        end
        in_valid[3] = 1'b0;
        wait_done(3, 10);
        check_result(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_error_accum.md
# approx_error_accum

Streaming error-statistics accumulator that sits directly downstream of the exact and approximate (SCDM) 8x8 multipliers. Each accepted sample is one exact/approximate result pair. Over a run of N_SAMPLES pairs the block computes:
- mismatch count
- sum of absolute error
- signed error sum
- maximum absolute error, and the sample index where it first occurred

This gives on-chip error characterisation of the approximate multipliers without dumping every result to a file.

## Interface

Parameters:
- W, 16: width of the exact and approximate results (unsigned).
- CNT_W, 17: width of the sample counters; N_SAMPLES ≤ 2^CNT_W − 1 is required.
- N_SAMPLES, 65536: number of samples per run (full 8x8 operand sweep).
- Derived: ACC_W = W + CNT_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- in_valid  in  1  the sample on exact/approx is valid this cycle.
- exact  in  W  exact product.
- approx  in  W  approximate product.
- in_ready  out  1  high only in the ACCUM state.
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  high in DONE; held until the next start or reset.
- sample_count  out  CNT_W  number of samples accepted this run.
- err_count  out  CNT_W  number of accepted samples with approx ≠ exact.
- sum_abs_err  out  ACC_W  Σ|approx − exact|.
- sum_signed_err  out  ACC_W+1  Σ(approx − exact), two's complement.
- max_abs_err  out  W  maximum |approx − exact| seen this run.
- max_at  out  CNT_W  0-based sample index of the first occurrence of max_abs_err.

## Operation

- FSM states are IDLE, ACCUM, DRAIN, DONE.
  - IDLE→ACCUM on start.
  - DONE→ACCUM on start.
  - ACCUM→DRAIN on the edge that accepts sample number N_SAMPLES.
  - DRAIN→DONE unconditionally, one cycle later.
- On start, all statistic outputs, sample_count and the pipeline valid bit clear to 0 on the same edge that enters ACCUM.
- start is ignored in ACCUM and DRAIN.
- A sample is accepted when in_valid && in_ready. in_valid is ignored in any other state.
- Samples are indexed by acceptance order, so gaps in in_valid do not advance the index.
- Stage 1 registers, for each accepted sample:
  - d = approx − exact as a (W+1)-bit signed value;
  - |d| as W bits (W bits are sufficient);
  - ne = (d ≠ 0);
  - the sample index;
  - a valid bit.
- Stage 2 runs when the stage-1 valid bit is set:
  - err_count += ne;
  - sum_abs_err += |d|;
  - sum_signed_err += sign-extended d;
  - if |d| > max_abs_err (strictly greater), max_abs_err and max_at are updated.
- Because the comparison is strict, ties keep the earlier index.
- sample_count increments at acceptance, in stage 0.
- Accumulator widths guarantee no overflow for any legal N_SAMPLES, so there is no saturation logic.
- The outputs are the accumulator registers themselves; they are stable and hold their final values throughout DONE.

## Timing

- Reset value of every output is 0, and state is IDLE.
- Asynchronous reset mid-run aborts the run: all outputs and pipeline state return to 0 immediately.
- Pipeline latency is one cycle: a sample accepted at edge E appears in the statistics at edge E+1.
- Throughput is one sample per cycle while in_valid is held high.
- If the final sample is accepted at edge E:
  - state is DRAIN after E;
  - the final statistics and done=1 are both visible after E+1;
  - busy=0 after E+1.
- in_ready falls on the same edge that accepts the final sample, so an (N_SAMPLES+1)-th sample is never accepted.
- A start that coincides with reset is ignored, because reset dominates.
- start asserted in DONE clears the results and sets in_ready=1 after that edge.

## Test plan

- **Reset:** hold rst_n=0 with random inputs → every output is 0, in_ready=0, busy=0, done=0.
  - Then release reset and pulse start → after the next edge in_ready=1, busy=1.
- **Exact-match run:** N_SAMPLES=4, pairs (100,100),(200,200),(300,300),(400,400) back-to-back →
  - err_count=0, sum_abs_err=0, sum_signed_err=0, max_abs_err=0, max_at=0, sample_count=4;
  - done=1 exactly one cycle after the 4th acceptance.
- **Mixed errors:** N_SAMPLES=4, (exact,approx) = (10,12),(50,45),(7,7),(1000,1003), with in_valid low for 2 cycles between samples →
  - err_count=3, sum_abs_err=10, sum_signed_err=0, max_abs_err=5, max_at=1.
- **Tie and extremes:** N_SAMPLES=3, (0,3),(5,2),(0xFFFF,0) →
  - max_abs_err=65535, max_at=2, sum_abs_err=65541, sum_signed_err=−65535.
  - Repeat with (0,3),(5,2) only (N_SAMPLES=2) → max_abs_err=3, max_at=0.
- **Protocol edges:** N_SAMPLES=4.
  - Pulse start during ACCUM → no effect.
  - Hold in_valid high past the 4th sample → sample_count stays 4.
  - Pulse start in DONE → all statistics clear on that edge and a new run proceeds.
- **Mid-run reset and full sweep:**
  - Assert rst_n=0 after 2 samples → all outputs 0, IDLE.
  - With default parameters, drive exact=approx=counter value for 65536 samples → sample_count=65536, err_count=0, done=1.
